data_bram_ctrl: RTL and testbench

//   Sequencer and read arbiter for the global data BRAM of the LSTM datapath.

---
 rtl/data_bram_ctrl_pkg.sv | 12 +
 rtl/data_bram_ctrl_rr_arb2.sv | 26 ++
 rtl/data_bram_ctrl.sv | 112 +++++++++++
 tb/tb_data_bram_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bram_ctrl_pkg.sv
// rtl/data_bram_ctrl_pkg.sv - state encodings and requester count shared by the data BRAM controllers
package data_bram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/data_bram_ctrl_rr_arb2.sv
// rtl/data_bram_ctrl_rr_arb2.sv - 2-way round-robin arbiter for a shared single-port resource
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // Index of the most recent winner; reset to 1 so requester 0 wins the first tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
  end

endmodule

// File: rtl/data_bram_ctrl.sv
// rtl/data_bram_ctrl.sv - load sequencer and two-requester read arbiter for the LSTM global data BRAM
module data_bram_ctrl
  import data_bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_wr_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  output logic                          bram_re,
  output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          loaded,
  output logic                          load_done
);

  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_cnt;
  logic [NUM_REQ-1:0]      grant;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    in_range;
  logic                    arb_en;

  // A restart request in SERVE takes the cycle, so no read is granted alongside it.
  assign arb_en = (state == ST_SERVE) && !start;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    sel_addr = '0;
    if (grant[1])      sel_addr = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
    else if (grant[0]) sel_addr = req_addr[0 +: ADDR_WIDTH];
  end

  assign in_range     = {1'b0, sel_addr} < MEM_LIMIT;
  assign in_ready     = (state == ST_LOAD);
  assign bram_we      = in_ready && in_valid;
  assign bram_wr_addr = in_ready ? wr_cnt : '0;
  assign bram_din     = in_ready ? in_data : '0;
  assign req_ready    = grant;
  assign bram_rd_addr = sel_addr;
  assign bram_re      = (|grant) && in_range;
  // Out-of-range responses carry zero data instead of whatever the BRAM last drove.
  assign rsp_data     = ((|rsp_valid) && !rsp_err) ? bram_dout : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      loaded    <= 1'b0;
      load_done <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      rsp_valid <= grant;
      rsp_err   <= (|grant) && !in_range;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOAD;
            wr_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (wr_cnt == LAST_ADDR) begin
              wr_cnt    <= '0;
              loaded    <= 1'b1;
              load_done <= 1'b1;
              state     <= ST_SERVE;
            end else begin
              wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        ST_SERVE: begin
          if (start) begin
            loaded <= 1'b0;
            wr_cnt <= '0;
            state  <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bram_ctrl.sv
// tb/tb_data_bram_ctrl.sv - self-checking bench for data_bram_ctrl with a cycle-level behavioural model
module tb_data_bram_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        bram_we;
  logic [6:0]  bram_wr_addr;
  logic [31:0] bram_din;
  logic        bram_re;
  logic [6:0]  bram_rd_addr;
  logic [31:0] bram_dout;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        loaded;
  logic        load_done;

  data_bram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .MEM_SIZE(96)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bram_we(bram_we), .bram_wr_addr(bram_wr_addr), .bram_din(bram_din),
    .bram_re(bram_re), .bram_rd_addr(bram_rd_addr), .bram_dout(bram_dout),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .loaded(loaded), .load_done(load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM macro stand-in: one-cycle registered read.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (bram_we) mem[bram_wr_addr] <= bram_din;
    if (bram_re) bram_dout <= mem[bram_rd_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int we_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (bram_we === 1'b1)   we_cnt++;
    if (load_done === 1'b1) done_cnt++;
  end

  // Behavioural model: mode 0 idle, 1 loading, 2 serving; shadow holds the loaded words.
  int          m_mode, m_cnt, m_last;
  bit          m_loaded, m_done, m_rsp_err;
  logic [1:0]  m_rsp_v;
  logic [31:0] m_rsp_data;
  logic [31:0] shadow [0:127];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_last = 1; m_loaded = 0; m_done = 0;
    m_rsp_v = 2'b00; m_rsp_err = 0; m_rsp_data = 0;
  endtask

  function automatic int exp_winner();
    if (m_mode != 2 || start || rst) return -1;
    if (req_valid == 2'b11) return 1 - m_last;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int a;
    if (rst) begin
      model_reset();
      return;
    end
    w = exp_winner();
    m_done = 0; m_rsp_v = 2'b00; m_rsp_err = 0; m_rsp_data = 0;
    if (w >= 0) begin
      a = (w == 1) ? int'(req_addr[13:7]) : int'(req_addr[6:0]);
      m_rsp_v    = 2'(1 << w);
      m_rsp_err  = (a >= 96);
      m_rsp_data = (a >= 96) ? 32'd0 : shadow[a];
      m_last     = w;
    end
    case (m_mode)
      0: if (start) begin m_mode = 1; m_cnt = 0; end
      1: if (in_valid) begin
        shadow[m_cnt] = in_data;
        if (m_cnt == 95) begin
          m_cnt = 0; m_loaded = 1; m_done = 1; m_mode = 2;
        end else m_cnt++;
      end
      2: if (start) begin m_mode = 1; m_cnt = 0; m_loaded = 0; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare();
    int w;
    int a;
    w = exp_winner();
    chk("in_ready", in_ready, m_mode == 1);
    chk("bram_we", bram_we, (m_mode == 1) && in_valid);
    if (m_mode == 1 && in_valid) begin
      chk("bram_wr_addr", bram_wr_addr, m_cnt);
      chk("bram_din", bram_din, in_data);
    end
    chk("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
    if (w >= 0) begin
      a = (w == 1) ? int'(req_addr[13:7]) : int'(req_addr[6:0]);
      chk("bram_rd_addr", bram_rd_addr, a);
      chk("bram_re", bram_re, a < 96);
    end else begin
      chk("bram_re_idle", bram_re, 0);
    end
    chk("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v != 2'b00) begin
      chk("rsp_err", rsp_err, m_rsp_err);
      chk("rsp_data", rsp_data, m_rsp_data);
    end
    chk("loaded", loaded, m_loaded);
    chk("load_done", load_done, m_done);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      compare();
      @(posedge clk);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  g_rec  [0:3];
  logic [1:0]  rv_rec [0:3];
  logic [31:0] rd_rec [0:3];
  logic [1:0]  pat_v  [0:9] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
  logic [6:0]  pat_a0 [0:9] = '{7'd0, 7'd1, 7'd95, 7'd96, 7'd10, 7'd0, 7'd127, 7'd44, 7'd2, 7'd63};
  logic [6:0]  pat_a1 [0:9] = '{7'd95, 7'd127, 7'd3, 7'd4, 7'd50, 7'd0, 7'd7, 7'd100, 7'd80, 7'd31};
  int base_we, base_done;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; req_valid = '0; req_addr = '0;
    tick(); tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_loaded", loaded, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_load_done", load_done, 0);
    rst = 1'b0;
    tick();

    // Full load of words 0..95, one per cycle.
    base_we = we_cnt; base_done = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 96; i++) begin
      in_valid = 1'b1; in_data = 32'(i); tick();
    end
    chk("load1_done_pulse", load_done, 1);
    chk("load1_loaded", loaded, 1);
    in_valid = 1'b0; tick();
    chk("load1_writes", we_cnt - base_we, 96);
    chk("load1_done_count", done_cnt - base_done, 1);

    // Tie between addrs 5 and 9 alternates starting with requester 0.
    req_valid = 2'b11; req_addr = {7'd9, 7'd5};
    for (int k = 0; k < 4; k++) begin
      #1; g_rec[k] = req_ready;
      tick();
      rv_rec[k] = rsp_valid; rd_rec[k] = rsp_data;
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", g_rec[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rsp_valid", rv_rec[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rsp_data", rd_rec[k], (k % 2 == 0) ? 32'd5 : 32'd9);
    end
    tick();

    // Out-of-range request is granted but not read.
    req_valid = 2'b01; req_addr = {7'd0, 7'd96};
    #1;
    chk("oor_req_ready", req_ready, 2'b01);
    chk("oor_bram_re", bram_re, 0);
    tick(); req_valid = 2'b00; #1;
    chk("oor_rsp_valid", rsp_valid, 2'b01);
    chk("oor_rsp_err", rsp_err, 1);
    chk("oor_rsp_data", rsp_data, 0);
    tick();

    // Grant to requester 1, then start: response still delivered, no new grant.
    req_valid = 2'b10; req_addr = {7'd20, 7'd0};
    #1; chk("pre_start_grant", req_ready, 2'b10);
    tick(); start = 1'b1; #1;
    chk("start_no_grant", req_ready, 2'b00);
    chk("start_rsp_valid", rsp_valid, 2'b10);
    chk("start_rsp_data", rsp_data, 20);
    tick(); start = 1'b0; req_valid = 2'b00; #1;
    chk("reload_loaded", loaded, 0);
    chk("reload_in_ready", in_ready, 1);

    // Reload with in_valid toggling; data 1000 + 3*addr.
    base_we = we_cnt; base_done = done_cnt;
    for (int i = 0; i < 192; i++) begin
      in_valid = (i % 2 == 0); in_data = 32'(1000 + 3 * (i / 2)); tick();
    end
    in_valid = 1'b1; in_data = 32'hdead; #1;
    chk("serve_no_write", bram_we, 0);
    tick(); in_valid = 1'b0;
    chk("load2_writes", we_cnt - base_we, 96);
    chk("load2_done_count", done_cnt - base_done, 1);
    for (int k = 0; k < 10; k++) begin
      req_valid = pat_v[k]; req_addr = {pat_a1[k], pat_a0[k]}; tick();
    end
    req_valid = 2'b00; tick();
    chk("load2_word95", mem[95], 1285);

    // Reset in the middle of a load, then reload from address 0.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 32'(7000 + i); tick();
    end
    in_valid = 1'b0; rst = 1'b1; #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_loaded", loaded, 0);
    tick(); rst = 1'b0; tick();
    chk("post_rst_in_ready", in_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'd5000; #1;
    chk("reload_first_addr", bram_wr_addr, 0);
    chk("reload_first_we", bram_we, 1);
    for (int i = 0; i < 96; i++) begin
      in_valid = 1'b1; in_data = 32'(5000 + i); tick();
    end
    in_valid = 1'b0;
    req_valid = 2'b11; req_addr = {7'd40, 7'd39}; tick();
    req_valid = 2'b00; #1;
    chk("after_rst_read", rsp_data, 5039);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
